// File: rtl/div_if.sv
// div_if: divide handshake between the control unit (master) and div_unit (slave).
// The div_zero flag exists only when DIV_ZERO_EXC_EN is defined.
interface div_if;
  logic        DIV_control;
  logic [31:0] A_in, B_in, LO_out, HI_out;
  logic        divStop, busy;
`ifdef DIV_ZERO_EXC_EN
  logic        div_zero;
  modport master (output DIV_control, A_in, B_in, input LO_out, HI_out, divStop, busy, div_zero);
  modport slave  (input DIV_control, A_in, B_in, output LO_out, HI_out, divStop, busy, div_zero);
`else
  modport master (output DIV_control, A_in, B_in, input LO_out, HI_out, divStop, busy);
  modport slave  (input DIV_control, A_in, B_in, output LO_out, HI_out, divStop, busy);
`endif
endinterface

// File: rtl/div_unit.sv
// div_unit: sequential signed 32-bit restoring divider (MIPS div semantics), 33 clocks per result.
// Define DIV_ZERO_EXC_EN to trap zero divisors with an immediate div_zero/divStop pulse.
module div_unit (
  input logic clk,
  input logic reset,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t      state;
  logic [31:0] dvd, dvsr, rem, a_abs, b_abs;
  logic [4:0]  count;
  logic        sign_q, sign_r;
  logic [32:0] sh, trial;
  // rem stays below dvsr (or below 2^31 for a zero divisor), so sh never reaches 2^32
  always_comb begin
    a_abs = bus.A_in[31] ? -bus.A_in : bus.A_in;
    b_abs = bus.B_in[31] ? -bus.B_in : bus.B_in;
    sh    = {rem, dvd[31]};
    trial = sh - {1'b0, dvsr};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dvd         <= '0;
      dvsr        <= '0;
      rem         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      bus.LO_out  <= '0;
      bus.HI_out  <= '0;
      bus.divStop <= 1'b0;
      bus.busy    <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      bus.div_zero <= 1'b0;
`endif
    end else begin
      bus.divStop <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      bus.div_zero <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.DIV_control) begin
`ifdef DIV_ZERO_EXC_EN
          if (bus.B_in == '0) begin
            bus.divStop  <= 1'b1;
            bus.div_zero <= 1'b1;
            state        <= DONE;
          end else
`endif
          begin
            dvd      <= a_abs;
            dvsr     <= b_abs;
            rem      <= '0;
            count    <= '0;
            sign_q   <= bus.A_in[31] ^ bus.B_in[31];
            sign_r   <= bus.A_in[31];
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          rem   <= trial[32] ? sh[31:0] : trial[31:0];
          dvd   <= {dvd[30:0], ~trial[32]};
          count <= count + 5'd1;
          state <= (count == 5'd31) ? FIX : RUN;
        end
        FIX: begin
          bus.LO_out  <= sign_q ? -dvd : dvd;
          bus.HI_out  <= sign_r ? -rem : rem;
          bus.divStop <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, hand-written corner sequences and random operands against an arithmetic model.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  div_if bus();
  div_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, lo, hi;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // MIPS div reference: truncating quotient, remainder follows the dividend
  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] lo, output logic [31:0] hi);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      hi = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      lo = sa / sb;
      hi = sa % sb;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.DIV_control = 1'b1;
    bus.A_in = a;
    bus.B_in = b;
    @(posedge clk);
    @(negedge clk);
    bus.DIV_control = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi, input string nm);
    int lat;
    bit busy_ok;
    start(a, b);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.divStop && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 33);
    chk({nm, " busy E0-E32"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, " busy low at E33"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, " LO"}, bus.LO_out, lo);
    chk({nm, " HI"}, bus.HI_out, hi);
    @(negedge clk);
    chk({nm, " divStop single cycle"}, {31'd0, bus.divStop}, 32'd0);
  endtask

  initial begin
    vec_t vt[$];
    logic [31:0] a, b, lo, hi;
    int pulses;
    bus.DIV_control = 1'b0;
    bus.A_in = '0;
    bus.B_in = '0;
    vt.push_back('{32'd7, 32'd2, 32'd3, 32'd1, "7/2"});
    vt.push_back('{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "-7/2"});
    vt.push_back('{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "7/-2"});
    vt.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "-7/-2"});
    vt.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "min/-1"});
    vt.push_back('{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, "min/1"});
    vt.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, "max/min"});
    vt.push_back('{32'd0, 32'd5, 32'd0, 32'd0, "0/5"});
    vt.push_back('{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "-100/7"});

    repeat (3) @(negedge clk);
    chk("reset LO", bus.LO_out, 32'd0);
    chk("reset HI", bus.HI_out, 32'd0);
    chk("reset divStop/busy", {30'd0, bus.divStop, bus.busy}, 32'd0);
    reset = 1'b1;

    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, vt[i].nm);

    run_op(32'd9, 32'd3, 32'd3, 32'd0, "9/3");
`ifdef DIV_ZERO_EXC_EN
    start(32'd5, 32'd0);
    chk("dz divStop at E1", {31'd0, bus.divStop}, 32'd1);
    chk("dz div_zero at E1", {31'd0, bus.div_zero}, 32'd1);
    chk("dz LO kept", bus.LO_out, 32'd3);
    chk("dz HI kept", bus.HI_out, 32'd0);
    @(negedge clk);
    chk("dz flags clear", {30'd0, bus.divStop, bus.div_zero}, 32'd0);
`else
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "5/0");
    run_op(32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, "-5/0");
`endif

    // start held high with new operands through the whole run and DONE
    @(negedge clk);
    bus.DIV_control = 1'b1;
    bus.A_in = 32'd100;
    bus.B_in = 32'd7;
    @(negedge clk);
    bus.A_in = 32'd9;
    bus.B_in = 32'd3;
    pulses = 0;
    repeat (34) begin
      @(negedge clk);
      pulses += int'(bus.divStop);
    end
    bus.DIV_control = 1'b0;
    chk("hold LO", bus.LO_out, 32'd14);
    chk("hold HI", bus.HI_out, 32'd2);
    repeat (40) begin
      @(negedge clk);
      pulses += int'(bus.divStop);
    end
    chk("hold single divStop", pulses, 1);

    // asynchronous reset in the middle of a run
    start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort LO", bus.LO_out, 32'd0);
    chk("abort HI", bus.HI_out, 32'd0);
    chk("abort divStop/busy", {30'd0, bus.divStop, bus.busy}, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(bus.divStop);
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(bus.divStop);
    end
    chk("abort no divStop", pulses, 0);
    run_op(32'd9, 32'd3, 32'd3, 32'd0, "after abort 9/3");

    for (int k = 0; k < 20; k++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
`ifdef DIV_ZERO_EXC_EN
      if (b == 32'd0) b = 32'd1;
`endif
      model(a, b, lo, hi);
      run_op(a, b, lo, hi, $sformatf("rand %0d %h/%h", k, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Sequential signed 32-bit divider that serves as the responder for the control unit's divide handshake. The control unit pulses `DIV_control` with operands on `A_in`/`B_in` (from registers A and B); the block runs a restoring shift-subtract loop and returns quotient on `LO_out` and remainder on `HI_out`, then pulses `divStop`. The results feed the HI/LO registers, which are loaded under `HILO_write`/`HILO_select`.

## Interface
Parameters: none (width fixed at 32).
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `DIV_control`  in  1  start request; sampled only in IDLE
- `A_in`  in  32  dividend, two's complement
- `B_in`  in  32  divisor, two's complement
- `LO_out`  out  32  quotient, registered; reset 0
- `HI_out`  out  32  remainder, registered; reset 0
- `divStop`  out  1  one-cycle completion pulse, registered; reset 0
- `busy`  out  1  high in RUN/FIX; reset 0
- `div_zero`  out  1  divide-by-zero flag, registered; reset 0; present only with `DIV_ZERO_EXC_EN`

## Operation
- States: IDLE, RUN, FIX, DONE. Reset → IDLE.
- IDLE:
  - When `DIV_control`=1 at a rising edge, latch `|A_in|` into the dividend shift register and `|B_in|` into the divisor register.
  - Record `sign_q = A[31]^B[31]` and `sign_r = A[31]`.
  - Clear the partial remainder to 0, set `count=0`, and go to RUN.
- RUN, one iteration per clock:
  - Shift `{rem, dvd}` left by 1.
  - Form `trial = rem - dvsr` at 33 bits.
  - If `trial` is non-negative, set `rem = trial` and the quotient LSB to 1; otherwise set the quotient LSB to 0.
  - After the 32nd iteration (`count==31`), go to FIX.
- FIX:
  - `LO_out = sign_q ? -q : q`; `HI_out = sign_r ? -rem : rem`, both mod 2^32.
  - Set `divStop` to 1 and go to DONE.
- DONE: `divStop` returns to 0 and the state returns to IDLE. In this state, `DIV_control` is ignored.
- `DIV_control` is ignored in RUN, FIX and DONE. A request is never queued.
- `LO_out`/`HI_out` change only at the FIX edge and hold between operations.
- Semantics are MIPS `div`: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- `0x80000000 / 0xFFFFFFFF`:
  - Magnitudes are 2^31 and 1, giving unsigned q=0x80000000.
  - With `sign_q`=0, LO=0x80000000 and HI=0. No overflow flag is raised.
- The absolute value of 0x80000000 is 0x80000000, read as unsigned 2^31. Internal magnitudes are unsigned 32-bit.
- Reset mid-operation:
  - Asynchronously returns to IDLE and zeroes all outputs.
  - No `divStop` is produced for the aborted request.

## Timing
- E0 is the edge that samples `DIV_control`=1 in IDLE.
- RUN iterations occur on edges E1–E32. The FIX edge is E33.
- `divStop` is high from E33 to E34. `LO_out`/`HI_out` are valid from E33 onward.
- Latency is 33 clocks from E0 to `divStop`. Earliest next accepted start is E35, since E34 lands in DONE and requests there are ignored.
- `busy` is high from E0 to E33.
- All outputs are driven from flops. There is no combinational path from inputs to outputs.

## Configuration
- `DIV_ZERO_EXC_EN` defined:
  - When E0 samples `B_in`=0, go directly to DONE and skip RUN/FIX.
  - At E0 set `divStop`=1 and `div_zero`=1. Both are high until E1.
  - `LO_out`/`HI_out` keep their previous values.
  - `div_zero` clears with `divStop`. Otherwise it reads 0.
- Not defined:
  - The `div_zero` port is absent and a zero divisor runs the normal 33-cycle loop.
  - Result with A ≥ 0: LO=0xFFFFFFFF. Result with A < 0: LO=0x00000001. In both cases HI=`A_in`.

## Test plan
- A=7, B=2, start pulse → `divStop` 33 clocks after E0; LO=0x00000003, HI=0x00000001; `busy` high exactly E0–E33.
- A=-7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; A=7, B=-2 → LO=0xFFFFFFFD, HI=0x00000001.
- A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- B=0, A=5:
  - With macro: `divStop`=`div_zero`=1 one clock after E0, prior LO/HI retained.
  - Without macro: LO=0xFFFFFFFF, HI=0x00000005 at E33.
- Start A=100, B=7; hold `DIV_control` high through the run with operands changed to 9/3 → single `divStop`, LO=14, HI=2; the second request is ignored.
- Start A=100, B=7; drive `reset` low at E10 → all outputs 0 immediately, no `divStop`. Release reset, start A=9, B=3 → LO=3, HI=0 after 33 clocks.
